bin2seg_scan: RTL and testbench

BIN2SEG_SCAN -- requirements
Module: bin2seg_scan

---
 rtl/bin2seg_scan.sv | 148 ++++++++++++++
 tb/tb_bin2seg_scan.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2seg_scan.sv
// bin2seg_scan: serial double-dabble binary-to-BCD converter driving a multiplexed,
// active-low seven-segment display with leading-zero blanking and overflow dashes.
module bin2seg_scan #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 50000,
   parameter int LZ_BLANK = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an
);
   localparam int BW = 4*DIGITS;
   localparam int SW = BW + WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t          state_q, state_d;
   logic [SW-1:0]   sr_q, sr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            acc_q, acc_d;
   logic            busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic [PW-1:0]   pre_q, pre_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [6:0]      seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d, hi_zero;
   logic [BW-1:0]   adj;
   logic [SW-1:0]   shifted;
   logic [3:0]      digit;
   logic            blank, z, wrap;
   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'b0000001;
         4'd1:    enc = 7'b1001111;
         4'd2:    enc = 7'b0010010;
         4'd3:    enc = 7'b0000110;
         4'd4:    enc = 7'b1001100;
         4'd5:    enc = 7'b0100100;
         4'd6:    enc = 7'b0100000;
         4'd7:    enc = 7'b0001111;
         4'd8:    enc = 7'b0000000;
         default: enc = 7'b0001100;
      endcase
   endfunction
   // add-3 correction on every nibble, then shift the whole {bcd,bin} register
   always_comb begin
      adj = sr_q[SW-1:WIDTH];
      for (int i = 0; i < DIGITS; i++)
         adj[4*i +: 4] = adj[4*i +: 4] >= 4'd5 ? adj[4*i +: 4] + 4'd3 : adj[4*i +: 4];
      shifted = {adj, sr_q[WIDTH-1:0]} << 1;
   end
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = SHIFT;
            sr_d    = {{BW{1'b0}}, bin};
            cnt_d   = '0;
            acc_d   = 1'b0;
            busy_d  = 1'b1;
         end
         SHIFT: begin
            sr_d   = shifted;
            cnt_d  = cnt_q + 1'b1;
            acc_d  = acc_q | adj[BW-1];
            busy_d = 1'b1;
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               bcd_d   = shifted[SW-1:WIDTH];
               ovf_d   = acc_q | adj[BW-1];
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   // hi_zero[i]: digit i and every digit above it are zero
   always_comb begin
      z = 1'b1;
      hi_zero = '0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         z = z & (bcd_q[4*i +: 4] == 4'd0);
         hi_zero[i] = z;
      end
      wrap  = pre_q == PW'(SCAN_DIV-1);
      pre_d = wrap ? '0 : pre_q + 1'b1;
      idx_d = wrap ? (idx_q == IW'(DIGITS-1) ? '0 : idx_q + 1'b1) : idx_q;
      digit = 4'(bcd_q >> {idx_q, 2'b00});
      blank = LZ_BLANK != 0 && idx_q != '0 && (hi_zero >> idx_q) != '0 && hi_zero[idx_q];
      seg_d = ovf_q ? 7'b1111110 : blank ? 7'b1111111 : enc(digit);
      an_d  = ~(DIGITS'(1) << idx_q);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         seg_q   <= 7'b0000001;
         an_q    <= ~DIGITS'(1);
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         bcd_q   <= bcd_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end
   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;
   assign bcd  = bcd_q;
   assign seg  = seg_q;
   assign an   = an_q;
endmodule

// File: tb/tb_bin2seg_scan.sv
// tb_bin2seg_scan: directed checks of conversion timing, BCD results and the scanned display
// on three configurations sharing one stimulus (3 digits, 2 digits, no blanking).
module tb_bin2seg_scan;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [7:0] bin = 8'd0;
   logic busy, done, ovf, busy2, done2, ovf2, busy3, done3, ovf3;
   logic [11:0] bcd, bcd3;
   logic [7:0] bcd2;
   logic [6:0] seg, seg2, seg3, r;
   logic [2:0] an, an3;
   logic [1:0] an2;
   int checks = 0, errors = 0;
   int d1, dd2, cur, prev, run, first_run, order_err, hot_err, run_err, dseen;
   int cnt [3];
   logic [11:0] bc1, bc2;

   bin2seg_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .LZ_BLANK(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
      .ovf(ovf), .bcd(bcd), .seg(seg), .an(an));
   bin2seg_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4), .LZ_BLANK(1)) u_d2 (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy2), .done(done2),
      .ovf(ovf2), .bcd(bcd2), .seg(seg2), .an(an2));
   bin2seg_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .LZ_BLANK(0)) u_lz0 (
      .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy3), .done(done3),
      .ovf(ovf3), .bcd(bcd3), .seg(seg3), .an(an3));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // wait until the selected DUT enables digit i, then return its segment pattern
   task automatic read_seg(input int sel, input int i, output logic [6:0] s);
      logic hit;
      hit = 1'b0;
      s = 7'bx;
      for (int n = 0; n < 40 && !hit; n++) begin
         @(negedge clk);
         if (sel == 0 && an == ~(3'b001 << i)) begin hit = 1'b1; s = seg; end
         if (sel == 1 && an2 == ~(2'b01 << i)) begin hit = 1'b1; s = seg2; end
         if (sel == 2 && an3 == ~(3'b001 << i)) begin hit = 1'b1; s = seg3; end
      end
      if (!hit) check("scan_timeout", 0, 1);
   endtask

   task automatic conv(input logic [7:0] v);
      int lat, b;
      lat = -1;
      b = 0;
      @(negedge clk);
      bin = v;
      start = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) b++;
         if (done) begin lat = n; break; end
         @(posedge clk);
      end
      check("latency", lat, 9);
      check("busy_cycles", b, 8);
      @(negedge clk);
      check("done_width", done, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_bcd", bcd, 0);
      check("rst_an", an, 3'b110);
      check("rst_seg", seg, 7'b0000001);
      check("rst_aux", {busy2, done2, busy3, done3, ovf3}, 0);
      rst = 1'b0;

      conv(8'd255);
      check("bcd_255", bcd, 12'h255);
      check("ovf_255", ovf, 0);
      read_seg(0, 0, r); check("seg255_d0", r, 7'b0100100);
      read_seg(0, 1, r); check("seg255_d1", r, 7'b0100100);
      read_seg(0, 2, r); check("seg255_d2", r, 7'b0010010);

      conv(8'd7);
      check("bcd_7", bcd, 12'h007);
      check("bcd_7_lz0", bcd3, 12'h007);
      read_seg(0, 0, r); check("seg7_d0", r, 7'b0001111);
      read_seg(0, 1, r); check("seg7_d1_blank", r, 7'b1111111);
      read_seg(0, 2, r); check("seg7_d2_blank", r, 7'b1111111);
      read_seg(2, 0, r); check("seg7_lz0_d0", r, 7'b0001111);
      read_seg(2, 1, r); check("seg7_lz0_d1", r, 7'b0000001);
      read_seg(2, 2, r); check("seg7_lz0_d2", r, 7'b0000001);

      conv(8'd0);
      check("bcd_0", bcd, 0);
      read_seg(0, 0, r); check("seg0_d0", r, 7'b0000001);
      read_seg(0, 1, r); check("seg0_d1_blank", r, 7'b1111111);

      conv(8'd105);
      check("bcd_105", bcd, 12'h105);
      read_seg(0, 0, r); check("seg105_d0", r, 7'b0100100);
      read_seg(0, 1, r); check("seg105_d1_zero", r, 7'b0000001);
      read_seg(0, 2, r); check("seg105_d2", r, 7'b1001111);

      conv(8'd100);
      check("bcd_100", bcd, 12'h100);
      check("ovf_100", ovf, 0);
      check("ovf2_100", ovf2, 1);
      check("bcd2_100", bcd2, 8'h00);
      read_seg(1, 0, r); check("seg2_100_d0", r, 7'b1111110);
      read_seg(1, 1, r); check("seg2_100_d1", r, 7'b1111110);

      conv(8'd99);
      check("ovf2_99", ovf2, 0);
      check("bcd2_99", bcd2, 8'h99);
      read_seg(1, 0, r); check("seg2_99_d0", r, 7'b0001100);
      read_seg(1, 1, r); check("seg2_99_d1", r, 7'b0001100);

      // start held high: back-to-back conversions, bin changes mid-conversion
      @(negedge clk);
      bin = 8'd200;
      start = 1'b1;
      d1 = -1;
      dd2 = -1;
      bc1 = '0;
      bc2 = '0;
      for (int n = 1; n <= 22; n++) begin
         @(negedge clk);
         if (n == 3) bin = 8'd50;
         if (n == 13) bin = 8'd77;
         if (done) begin
            if (d1 < 0) begin d1 = n; bc1 = bcd; end
            else if (dd2 < 0) begin dd2 = n; bc2 = bcd; end
         end
      end
      start = 1'b0;
      repeat (12) @(negedge clk);
      check("b2b_first_done", d1, 10);
      check("b2b_second_done", dd2, 20);
      check("b2b_first_bcd", bc1, 12'h200);
      check("b2b_second_bcd", bc2, 12'h050);
      check("b2b_third_bcd", bcd, 12'h077);

      // reset 3 cycles into a conversion
      @(negedge clk);
      bin = 8'd200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_bcd", bcd, 0);
      check("abort_an", an, 3'b110);
      check("abort_seg", seg, 7'b0000001);
      @(negedge clk);
      rst = 1'b0;
      dseen = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dseen++;
      end
      check("abort_no_done", dseen, 0);
      check("abort_bcd_hold", bcd, 0);
      conv(8'd200);
      check("bcd_200", bcd, 12'h200);

      // free-running scan: 3 frames
      cnt = '{0, 0, 0};
      prev = -1;
      run = 0;
      first_run = 1;
      order_err = 0;
      hot_err = 0;
      run_err = 0;
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         cur = an == 3'b110 ? 0 : an == 3'b101 ? 1 : an == 3'b011 ? 2 : -1;
         if (cur < 0) hot_err++;
         else begin
            cnt[cur]++;
            if (prev >= 0 && cur != prev) begin
               if (cur != (prev + 1) % 3) order_err++;
               if (!first_run && run != 4) run_err++;
               first_run = 0;
               run = 0;
            end
            run++;
            prev = cur;
         end
      end
      check("scan_cnt0", cnt[0], 12);
      check("scan_cnt1", cnt[1], 12);
      check("scan_cnt2", cnt[2], 12);
      check("scan_order", order_err, 0);
      check("scan_onehot", hot_err, 0);
      check("scan_run", run_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
